core_dmem_responder: RTL and testbench

Memory-side responder for the core data-memory request/grant interface. It accepts dmem requests, inserts a programmable number of wait states before granting, and executes byte-strobed writes or 64-bit reads against an internal word array. It returns read data and an access-error flag on the cycle after each grant. It acts as the memory model in core-level benches and as the tightly-coupled data RAM wrapper in the SoC.

---
 rtl/core_dmem_responder.sv | 103 ++++++++++
 tb/tb_core_dmem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dmem_responder.sv
// Data-memory responder: wait-state insertion, byte-strobed 64-bit writes,
// registered 64-bit reads and an access-error flag one cycle after grant.
module core_dmem_responder #(
   parameter logic [63:0] MEM_BASE    = 64'h0000_0000_8000_0000,
   parameter int          MEM_SIZE    = 4096,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        dmem_req,
   input  logic [63:0] dmem_addr,
   input  logic        dmem_wen,
   input  logic [7:0]  dmem_strb,
   input  logic [63:0] dmem_wdata,
   output logic        dmem_gnt,
   output logic        dmem_err,
   output logic [63:0] dmem_rdata,
   output logic        rsp_valid
);

   localparam int          WORDS    = MEM_SIZE / 8;
   localparam int          IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [3:0]  WAIT_VAL = 4'(WAIT_CYCLES);

   // True when the byte address falls inside the array window.
   function automatic logic addr_in_range(input logic [63:0] addr);
      logic [63:0] off;
      off = addr - MEM_BASE;
      return (addr >= MEM_BASE) && (off < 64'(MEM_SIZE));
   endfunction

   // Word index of an in-range address; the low three bits select lanes only.
   function automatic logic [IW-1:0] word_index(input logic [63:0] addr);
      logic [63:0] off;
      off = addr - MEM_BASE;
      return IW'(off >> 3);
   endfunction

   logic [63:0]   mem [0:WORDS-1];
   logic [3:0]    cnt;

   logic          err_p0;
   logic [IW-1:0] idx_p0;
   logic          wr_en_p0;
   logic          rd_en_p0;

   logic          vld_p1;
   logic          err_p1;
   logic [63:0]   rdata_p1;

   // Grant-cycle decode: request, address window and strobe validity.
   always_comb begin
      dmem_gnt = dmem_req && (cnt == WAIT_VAL);
      err_p0   = !addr_in_range(dmem_addr) || (dmem_wen && (dmem_strb == 8'h00));
      idx_p0   = word_index(dmem_addr);
      wr_en_p0 = dmem_gnt && !g_reset && dmem_wen && !err_p0;
      rd_en_p0 = !dmem_wen && !err_p0;
   end

   // Wait-state counter; any drop of the request or a grant restarts it.
   always_ff @(posedge g_clk) begin
      if (g_reset || !dmem_req || dmem_gnt)
         cnt <= 4'd0;
      else
         cnt <= cnt + 4'd1;
   end

   // Byte-lane writes into the array; disabled lanes keep their contents.
   always_ff @(posedge g_clk) begin
      if (wr_en_p0) begin
         for (int i = 0; i < 8; i++) begin
            if (dmem_strb[i])
               mem[idx_p0][8*i +: 8] <= dmem_wdata[8*i +: 8];
         end
      end
   end

   // ---- grant (p0) -> response (p1) ----
   // Registered read port; writes and errors return zero data.
   always_ff @(posedge g_clk) begin
      if (g_reset)
         rdata_p1 <= 64'd0;
      else if (dmem_gnt)
         rdata_p1 <= rd_en_p0 ? mem[idx_p0] : 64'd0;
   end

   // Response valid pulses once per grant; error is held until the next grant.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         vld_p1 <= 1'b0;
         err_p1 <= 1'b0;
      end else begin
         vld_p1 <= dmem_gnt;
         if (dmem_gnt)
            err_p1 <= err_p0;
      end
   end

   assign rsp_valid  = vld_p1;
   assign dmem_err   = err_p1;
   assign dmem_rdata = rdata_p1;

endmodule

// File: tb/tb_core_dmem_responder.sv
// Bench for core_dmem_responder: one instance with no wait states and one
// with three, checked against a byte-array reference of the memory window.
module tb_core_dmem_responder;

   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
   localparam int          SIZE = 4096;
   localparam int          WAIT3 = 3;

   logic        clk = 1'b0;
   logic        g_reset;
   logic        req0, req3;
   logic [63:0] addr, wdata;
   logic        wen;
   logic [7:0]  strb;
   logic        gnt0, err0, rv0, gnt3, err3, rv3;
   logic [63:0] rdata0, rdata3;

   logic [7:0]  mm [2][SIZE];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   core_dmem_responder #(.MEM_BASE(BASE), .MEM_SIZE(SIZE), .WAIT_CYCLES(0)) dut0 (
      .g_clk(clk), .g_reset(g_reset), .dmem_req(req0), .dmem_addr(addr),
      .dmem_wen(wen), .dmem_strb(strb), .dmem_wdata(wdata), .dmem_gnt(gnt0),
      .dmem_err(err0), .dmem_rdata(rdata0), .rsp_valid(rv0));

   core_dmem_responder #(.MEM_BASE(BASE), .MEM_SIZE(SIZE), .WAIT_CYCLES(WAIT3)) dut3 (
      .g_clk(clk), .g_reset(g_reset), .dmem_req(req3), .dmem_addr(addr),
      .dmem_wen(wen), .dmem_strb(strb), .dmem_wdata(wdata), .dmem_gnt(gnt3),
      .dmem_err(err3), .dmem_rdata(rdata3), .rsp_valid(rv3));

   // Reference access on a byte array: returns the error flag and response data.
   task automatic model(input int which, input logic [63:0] a, input logic w,
                        input logic [7:0] s, input logic [63:0] d,
                        output logic e, output logic [63:0] r);
      logic [63:0] off;
      int          bo;
      off = a - BASE;
      e = !((a >= BASE) && (off < 64'(SIZE))) || (w && s == 8'h00);
      r = 64'd0;
      if (!e) begin
         bo = int'(off[11:0]) & ~7;
         for (int i = 0; i < 8; i++) begin
            if (w && s[i]) mm[which][bo+i] = d[8*i +: 8];
            if (!w) r[8*i +: 8] = mm[which][bo+i];
         end
      end
   endtask

   // One transaction on the zero-wait instance; starts just after a rising edge.
   task automatic txn0(input logic [63:0] a, input logic w, input logic [7:0] s,
                       input logic [63:0] d, output logic [63:0] got);
      logic        e;
      logic [63:0] r;
      addr = a; wen = w; strb = s; wdata = d; req0 = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1) begin errors++; $display("FAIL gnt0: got %b want 1", gnt0); end
      checks++;
      if (rv0 !== 1'b0) begin errors++; $display("FAIL rv0_idle: got %b want 0", rv0); end
      model(0, a, w, s, d, e, r);
      @(posedge clk); #1;
      req0 = 1'b0; addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (rv0 !== 1'b1) begin errors++; $display("FAIL rv0: got %b want 1", rv0); end
      checks++;
      if (err0 !== e) begin errors++; $display("FAIL err0 a=%h: got %b want %b", a, err0, e); end
      checks++;
      if (rdata0 !== r) begin errors++; $display("FAIL rdata0 a=%h: got %h want %h", a, rdata0, r); end
      got = rdata0;
      @(posedge clk); #1;
   endtask

   // One request on the three-wait instance held for up to 'hold' cycles.
   // Address/data are scrambled during wait cycles and valid only when a grant is due.
   task automatic txn3(input logic [63:0] a, input logic w, input logic [7:0] s,
                       input logic [63:0] d, input int hold);
      logic        e, got;
      logic [63:0] r;
      got = 1'b0; e = 1'b0; r = 64'd0;
      req3 = 1'b1;
      for (int k = 1; k <= hold; k++) begin
         if (k == WAIT3 + 1) begin
            addr = a; wen = w; strb = s; wdata = d;
         end else begin
            addr = {$urandom, $urandom}; wen = 1'($urandom); strb = 8'($urandom);
            wdata = {$urandom, $urandom};
         end
         @(negedge clk);
         checks++;
         if (gnt3 !== (k == WAIT3 + 1)) begin
            errors++; $display("FAIL gnt3 cycle %0d: got %b want %b", k, gnt3, (k == WAIT3 + 1));
         end
         checks++;
         if (rv3 !== 1'b0) begin errors++; $display("FAIL rv3_wait cycle %0d: got %b want 0", k, rv3); end
         if (k == WAIT3 + 1) begin
            model(1, a, w, s, d, e, r);
            got = 1'b1;
         end
         @(posedge clk); #1;
         if (got) break;
      end
      req3 = 1'b0;
      @(negedge clk);
      checks++;
      if (rv3 !== got) begin errors++; $display("FAIL rv3: got %b want %b", rv3, got); end
      if (got) begin
         checks++;
         if (err3 !== e) begin errors++; $display("FAIL err3 a=%h: got %b want %b", a, err3, e); end
         checks++;
         if (rdata3 !== r) begin errors++; $display("FAIL rdata3 a=%h: got %h want %h", a, rdata3, r); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      g_reset = 1'b1; req0 = 1'b0; req3 = 1'b0;
      addr = 64'd0; wen = 1'b0; strb = 8'h00; wdata = 64'd0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (gnt0 !== 1'b0)   begin errors++; $display("FAIL rst_gnt0: got %b want 0", gnt0); end
      checks++; if (gnt3 !== 1'b0)   begin errors++; $display("FAIL rst_gnt3: got %b want 0", gnt3); end
      checks++; if (rv0 !== 1'b0)    begin errors++; $display("FAIL rst_rv0: got %b want 0", rv0); end
      checks++; if (err0 !== 1'b0)   begin errors++; $display("FAIL rst_err0: got %b want 0", err0); end
      checks++; if (rdata0 !== 64'd0) begin errors++; $display("FAIL rst_rdata0: got %h want 0", rdata0); end
      checks++; if (rv3 !== 1'b0)    begin errors++; $display("FAIL rst_rv3: got %b want 0", rv3); end
      @(posedge clk); #1;
      g_reset = 1'b0;
   endtask

   task automatic test_preload();
      logic [63:0] g;
      for (int i = 0; i < 32; i++) txn0(BASE + 64'(8*i), 1'b1, 8'hFF, {$urandom, $urandom}, g);
      for (int i = 0; i < 8; i++)  txn3(BASE + 64'(8*i), 1'b1, 8'hFF, {$urandom, $urandom}, 4);
   endtask

   task automatic test_basic();
      logic [63:0] g;
      txn0(64'h8000_0010, 1'b1, 8'hFF, 64'h1122_3344_5566_7788, g);
      txn0(64'h8000_0010, 1'b0, 8'h00, 64'd0, g);
      checks++;
      if (g !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL basic_rd: got %h want 1122334455667788", g); end
      @(negedge clk);
      checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL rv0_pulse: got %b want 0", rv0); end
      @(posedge clk); #1;
   endtask

   task automatic test_partial();
      logic [63:0] g;
      txn0(64'h8000_0010, 1'b1, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, g);
      txn0(64'h8000_0013, 1'b0, 8'h00, 64'd0, g);
      checks++;
      if (g !== 64'h1122_3344_BBBB_BBBB) begin errors++; $display("FAIL partial_rd: got %h want 11223344BBBBBBBB", g); end
   endtask

   task automatic test_wait();
      txn3(BASE + 64'h18, 1'b0, 8'h00, 64'd0, 6);
      txn3(BASE + 64'h18, 1'b1, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 2);
      txn3(BASE + 64'h18, 1'b0, 8'h00, 64'd0, 6);
   endtask

   task automatic test_errors();
      logic [63:0] g;
      txn0(64'h7FFF_FFF8, 1'b0, 8'h00, 64'd0, g);
      txn0(64'h8000_1000, 1'b0, 8'h00, 64'd0, g);
      txn0(64'h8000_1000, 1'b1, 8'hFF, 64'h5555_5555_5555_5555, g);
      txn0(BASE - 64'd8,  1'b1, 8'hFF, 64'h6666_6666_6666_6666, g);
      txn0(BASE,          1'b0, 8'h00, 64'd0, g);
      txn0(BASE + 64'h20, 1'b1, 8'h00, 64'h7777_7777_7777_7777, g);
      txn0(BASE + 64'h20, 1'b0, 8'h00, 64'd0, g);
      txn3(64'h7FFF_FFF8, 1'b0, 8'h00, 64'd0, 4);
   endtask

   task automatic test_back_to_back();
      logic        e [3];
      logic [63:0] r [3];
      logic [63:0] a [3];
      logic        w [3];
      logic [63:0] d;
      a[0] = BASE + 64'h40; a[1] = BASE + 64'h40; a[2] = BASE + 64'h48;
      w[0] = 1'b1; w[1] = 1'b0; w[2] = 1'b0;
      d = {$urandom, $urandom};
      for (int t = 0; t < 4; t++) begin
         if (t < 3) begin
            req0 = 1'b1; addr = a[t]; wen = w[t]; strb = 8'hFF; wdata = d;
         end else begin
            req0 = 1'b0;
         end
         @(negedge clk);
         if (t < 3) begin
            checks++;
            if (gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_gnt t=%0d: got %b want 1", t, gnt0); end
            model(0, a[t], w[t], 8'hFF, d, e[t], r[t]);
         end
         checks++;
         if (rv0 !== (t > 0)) begin errors++; $display("FAIL b2b_rv t=%0d: got %b want %b", t, rv0, (t > 0)); end
         if (t > 0) begin
            checks++;
            if (err0 !== e[t-1]) begin errors++; $display("FAIL b2b_err t=%0d: got %b want %b", t, err0, e[t-1]); end
            checks++;
            if (rdata0 !== r[t-1]) begin errors++; $display("FAIL b2b_rdata t=%0d: got %h want %h", t, rdata0, r[t-1]); end
         end
         @(posedge clk); #1;
      end
      checks++;
      if (r[1] !== d) begin errors++; $display("FAIL b2b_raw: got %h want %h", r[1], d); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] g;
      txn0(BASE + 64'h8, 1'b0, 8'h00, 64'd0, g);
      txn3(BASE + 64'h8, 1'b0, 8'h00, 64'd0, 4);
      req3 = 1'b1; addr = BASE + 64'h10; wen = 1'b0; strb = 8'h00;
      @(negedge clk);
      checks++; if (gnt3 !== 1'b0) begin errors++; $display("FAIL rm_gnt3_c1: got %b want 0", gnt3); end
      @(posedge clk); #1;
      g_reset = 1'b1; req0 = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      g_reset = 1'b0; req0 = 1'b0;
      @(negedge clk);
      checks++; if (rv3 !== 1'b0)     begin errors++; $display("FAIL rm_rv3: got %b want 0", rv3); end
      checks++; if (err3 !== 1'b0)    begin errors++; $display("FAIL rm_err3: got %b want 0", err3); end
      checks++; if (rdata3 !== 64'd0) begin errors++; $display("FAIL rm_rdata3: got %h want 0", rdata3); end
      checks++; if (rv0 !== 1'b0)     begin errors++; $display("FAIL rm_rv0: got %b want 0", rv0); end
      checks++; if (rdata0 !== 64'd0) begin errors++; $display("FAIL rm_rdata0: got %h want 0", rdata0); end
      @(posedge clk); #1;
      req3 = 1'b0;
      @(posedge clk); #1;
      txn3(BASE + 64'h10, 1'b0, 8'h00, 64'd0, 6);
   endtask

   task automatic test_random();
      logic [63:0] g, a;
      logic        w;
      logic [7:0]  s;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 7))
            0:       a = BASE - 64'($urandom_range(1, 4096));
            1:       a = BASE + 64'(SIZE) + 64'($urandom_range(0, 4096));
            default: a = BASE + 64'($urandom_range(0, 255));
         endcase
         w = 1'($urandom);
         s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         if (n % 4 == 3) txn3(a & 64'hFFFF_FFFF_FFFF_FF3F, w, s, {$urandom, $urandom}, $urandom_range(1, 6));
         else            txn0(a, w, s, {$urandom, $urandom}, g);
      end
   endtask

   initial begin
      test_reset();
      test_preload();
      test_basic();
      test_partial();
      test_wait();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
